// File: rtl/design_test_driver_if.sv
// Pin bundle between design_test_driver and the my_design under test.
// Signal names are written from the driver's point of view.
interface design_test_driver_if #(
  parameter int ERR_W = 8
);
  logic             i_Start;
  logic [3:0]       o_Input;
  logic [1:0]       i_Output;
  logic             i_OutputFF;
  logic             o_Busy;
  logic             o_Done;
  logic             o_Pass;
  logic [ERR_W-1:0] o_ErrorCount;
  logic             o_FailValid;
  logic [3:0]       o_FailVector;

  // The driver itself.
  modport slave (
    input  i_Start, i_Output, i_OutputFF,
    output o_Input, o_Busy, o_Done, o_Pass, o_ErrorCount, o_FailValid, o_FailVector
  );

  // Whoever starts the run and hosts the design under test.
  modport master (
    output i_Start, i_Output, i_OutputFF,
    input  o_Input, o_Busy, o_Done, o_Pass, o_ErrorCount, o_FailValid, o_FailVector
  );
endinterface

// File: rtl/design_test_driver.sv
// Self-checking stimulus/response driver for my_design: exhaustive 4-bit sweep,
// plus an optional LFSR tail enabled by the DESIGN_TEST_LFSR_EN macro.
module design_test_driver #(
  parameter int HOLD_CYCLES = 2,
  parameter int ERR_W       = 8
`ifdef DESIGN_TEST_LFSR_EN
  , parameter int         LFSR_VECTORS = 64,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
`endif
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  design_test_driver_if.slave   io_Bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

`ifdef DESIGN_TEST_LFSR_EN
  localparam int NUM_VEC = 16 + LFSR_VECTORS;
`else
  localparam int NUM_VEC = 16;
`endif
  localparam int                 IDX_W     = $clog2(NUM_VEC + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_VEC - 1);
  localparam logic [7:0]         LAST_HOLD = 8'(HOLD_CYCLES - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_hold;
  logic [3:0]       r_input;
  logic [ERR_W-1:0] r_err;
  logic             r_fail_valid;
  logic [3:0]       r_fail_vec;

  logic             w_last_hold;
  logic             w_last_vec;
  logic             w_mismatch;
  logic [3:0]       w_next_vec;

  assign w_last_hold = (r_hold == LAST_HOLD);
  assign w_last_vec  = (r_idx == LAST_IDX);

  // Golden my_design: out0 = v0&v1, out1 = v2|v3, ff = ~(~v0 & v1).
  assign w_mismatch = (io_Bus.i_Output[0] != (r_input[0] & r_input[1])) ||
                      (io_Bus.i_Output[1] != (r_input[2] | r_input[3])) ||
                      (io_Bus.i_OutputFF  != (r_input[0] | ~r_input[1]));

`ifdef DESIGN_TEST_LFSR_EN
  logic [7:0] r_lfsr;
  logic [7:0] w_lfsr_next;

  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};

  // Vector 15 hands over to the current LFSR state; later vectors use the advanced state.
  always_comb begin
    if (r_idx < IDX_W'(15))       w_next_vec = r_input + 4'd1;
    else if (r_idx == IDX_W'(15)) w_next_vec = r_lfsr[3:0];
    else                          w_next_vec = w_lfsr_next[3:0];
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset)
      r_lfsr <= LFSR_SEED;
    else if ((r_state != RUN) && io_Bus.i_Start)
      r_lfsr <= LFSR_SEED;
    else if ((r_state == RUN) && w_last_hold && (r_idx >= IDX_W'(16)))
      r_lfsr <= w_lfsr_next;
  end
`else
  assign w_next_vec = r_input + 4'd1;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, DONE: if (io_Bus.i_Start) w_next_state = RUN;
      RUN:        if (w_last_hold && w_last_vec) w_next_state = DONE;
      default:    w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_idx        <= '0;
      r_hold       <= '0;
      r_input      <= '0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_last_hold) begin
            r_hold  <= '0;
            r_idx   <= r_idx + IDX_W'(1);
            r_input <= w_last_vec ? 4'd0 : w_next_vec;
            if (w_mismatch) begin
              if (r_err != '1) r_err <= r_err + ERR_W'(1);
              if (!r_fail_valid) begin
                r_fail_valid <= 1'b1;
                r_fail_vec   <= r_input;
              end
            end
          end else begin
            r_hold <= r_hold + 8'd1;
          end
        end
        default: begin
          r_input <= 4'd0;
          if (io_Bus.i_Start) begin
            r_idx        <= '0;
            r_hold       <= '0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    io_Bus.o_Input      = r_input;
    io_Bus.o_Busy       = (r_state == RUN);
    io_Bus.o_Done       = (r_state == DONE);
    io_Bus.o_Pass       = (r_state == DONE) && (r_err == '0);
    io_Bus.o_ErrorCount = r_err;
    io_Bus.o_FailValid  = r_fail_valid;
    io_Bus.o_FailVector = r_fail_vec;
  end

endmodule
